game_flow_controller: RTL and testbench



---
 rtl/game_flow_controller.sv | 142 ++++++++++++++
 tb/tb_game_flow_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Game-flow sequencer for the pinball design: attract, level load/play/clear, pause, game over and win screens.
// Optional pause support is compiled in when GAME_FLOW_PAUSE_EN is defined.
module game_flow_controller #(
  parameter int unsigned LIFE_W       = 4,
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned CLEAR_CYCLES = 50_000_000,
  parameter int unsigned OVER_CYCLES  = 150_000_000
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start_key,
  input  logic              pause_key,
  input  logic [LIFE_W-1:0] life,
  input  logic              level_done,
  output logic              start,
  output logic              game_end,
  output logic              paused,
  output logic              win,
  output logic              level_load,
  output logic [3:0]        level
);

  localparam int unsigned MAX_CYCLES = (CLEAR_CYCLES > OVER_CYCLES) ? CLEAR_CYCLES : OVER_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

  localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] OVER_LAST  = TW'((OVER_CYCLES == 0) ? 0 : OVER_CYCLES - 1);
  localparam logic [3:0]    LEVEL_LAST = 4'(NUM_LEVELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd5;
  localparam logic [2:0] S_WIN   = 3'd6;
`ifdef GAME_FLOW_PAUSE_EN
  localparam logic [2:0] S_PAUSE = 3'd4;
`endif

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt, timer_inc;
  logic [3:0]    level_nxt;
  logic          start_key_d;
  logic          start_rise;

  assign start_rise = start_key & ~start_key_d;

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_key_d;
  logic pause_rise;

  assign pause_rise = pause_key & ~pause_key_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) pause_key_d <= 1'b0;
    else         pause_key_d <= pause_key;
  end
`else
  logic unused_pause_key;
  assign unused_pause_key = pause_key;
`endif

  // Timer saturates instead of wrapping, so a stay-forever OVER/WIN never aliases a timeout.
  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    level_nxt = level;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          state_nxt = S_LOAD;
          level_nxt = '0;
        end
      end
      S_LOAD: state_nxt = S_PLAY;
      S_PLAY: begin
        if (life == '0) begin
          state_nxt = S_OVER;
          timer_nxt = '0;
        end else if (level_done) begin
          state_nxt = (level == LEVEL_LAST) ? S_WIN : S_CLEAR;
          timer_nxt = '0;
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (pause_rise) begin
          state_nxt = S_PAUSE;
        end
`endif
      end
      S_CLEAR: begin
        if (timer == CLEAR_LAST) begin
          state_nxt = S_LOAD;
          level_nxt = (level < LEVEL_LAST) ? level + 4'd1 : level;
        end else begin
          timer_nxt = timer_inc;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE: begin
        if (pause_rise) state_nxt = S_PLAY;
      end
`endif
      S_OVER, S_WIN: begin
        // Level returns to 0 with the attract screen so IDLE shows all-zero outputs.
        if ((OVER_CYCLES != 0) && (timer == OVER_LAST)) begin
          state_nxt = S_IDLE;
          level_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      timer       <= '0;
      level       <= '0;
      start_key_d <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      level       <= level_nxt;
      start_key_d <= start_key;
    end
  end

  assign start      = (state != S_IDLE);
  assign game_end   = (state == S_OVER) || (state == S_WIN);
  assign win        = (state == S_WIN);
  assign level_load = (state == S_LOAD);
`ifdef GAME_FLOW_PAUSE_EN
  assign paused     = (state == S_PAUSE);
`else
  assign paused     = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random play checked against a countdown-based screen model.
module tb_game_flow_controller;

  localparam int NL = 2;
  localparam int CC = 4;
  localparam int OC = 6;
`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start_key = 1'b0, pause_key = 1'b0, level_done = 1'b0;
  logic [3:0] life = 4'd3;
  logic       start, game_end, paused, win, level_load;
  logic [3:0] level;

  logic       b_start_key = 1'b0, b_pause_key = 1'b0, b_level_done = 1'b0;
  logic [3:0] b_life = 4'd3;
  logic       start_b, game_end_b, paused_b, win_b, level_load_b;
  logic [3:0] level_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_flow_controller #(
    .LIFE_W(4), .NUM_LEVELS(NL), .CLEAR_CYCLES(CC), .OVER_CYCLES(OC)
  ) dut (
    .clk(clk), .resetN(resetN), .start_key(start_key), .pause_key(pause_key),
    .life(life), .level_done(level_done), .start(start), .game_end(game_end),
    .paused(paused), .win(win), .level_load(level_load), .level(level)
  );

  game_flow_controller #(
    .LIFE_W(4), .NUM_LEVELS(NL), .CLEAR_CYCLES(CC), .OVER_CYCLES(0)
  ) dut_hold (
    .clk(clk), .resetN(resetN), .start_key(b_start_key), .pause_key(b_pause_key),
    .life(b_life), .level_done(b_level_done), .start(start_b), .game_end(game_end_b),
    .paused(paused_b), .win(win_b), .level_load(level_load_b), .level(level_b)
  );

  typedef enum {M_IDLE, M_LOAD, M_PLAY, M_CLEAR, M_PAUSE, M_OVER, M_WIN} mode_t;
  mode_t m_mode;
  int    m_left;
  int    m_lvl;
  bit    m_sk_prev, m_pk_prev;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_lvl = 0;
    m_sk_prev = 1'b0;
    m_pk_prev = 1'b0;
  endtask

  // Screen model: m_left counts remaining cycles on the timed screens.
  task automatic model_edge(input logic sk, input logic pk, input logic [3:0] lf, input logic ld);
    bit srise, prise;
    srise = sk && !m_sk_prev;
    prise = pk && !m_pk_prev;
    m_sk_prev = sk;
    m_pk_prev = pk;
    case (m_mode)
      M_IDLE: if (srise) begin m_mode = M_LOAD; m_lvl = 0; end
      M_LOAD: m_mode = M_PLAY;
      M_PLAY: begin
        if (lf == 4'd0) begin
          m_mode = M_OVER; m_left = OC;
        end else if (ld) begin
          if (m_lvl == NL - 1) begin m_mode = M_WIN; m_left = OC; end
          else begin m_mode = M_CLEAR; m_left = CC; end
        end else if (PAUSE_EN && prise) begin
          m_mode = M_PAUSE;
        end
      end
      M_CLEAR: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_lvl = (m_lvl + 1 > NL - 1) ? NL - 1 : m_lvl + 1;
          m_mode = M_LOAD;
        end
      end
      M_PAUSE: if (prise) m_mode = M_PLAY;
      M_OVER, M_WIN: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = M_IDLE; m_lvl = 0; end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag);
    logic [8:0] obs, exp;
    obs = {start, game_end, paused, win, level_load, level};
    exp = {m_mode != M_IDLE, (m_mode == M_OVER) || (m_mode == M_WIN), m_mode == M_PAUSE,
           m_mode == M_WIN, m_mode == M_LOAD, 4'(m_lvl)};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (start,game_end,paused,win,level_load,level)", tag, obs, exp);
    end
  endtask

  task automatic check_hold(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {start_b, game_end_b, paused_b, win_b, level_load_b, level_b};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (start,game_end,paused,win,level_load,level)", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic sk, input logic pk, input logic [3:0] lf, input logic ld);
    start_key = sk;
    pause_key = pk;
    life = lf;
    level_done = ld;
    @(posedge clk);
    model_edge(sk, pk, lf, ld);
    #1;
    check(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state");
    check_hold("hold_reset_state", 9'b0);
    resetN = 1'b1;

    // Held start key gives a single LOAD
    repeat (5) step("t1_start_held", 1, 0, 3, 0);
    step("t1_release", 0, 0, 3, 0);

    // Level clear, next level, win, timed return to attract
    step("t2_level_done", 0, 0, 3, 1);
    repeat (3) step("t2_clear", 0, 0, 3, 0);
    step("t2_load_next", 0, 0, 3, 0);
    step("t2_play_next", 0, 0, 3, 0);
    step("t2_last_done", 0, 0, 3, 1);
    repeat (6) step("t2_win_screen", 0, 0, 3, 0);
    step("t2_idle", 0, 0, 3, 0);

    // Loss beats simultaneous level_done; restart at level 0
    step("t3_start", 1, 0, 3, 0);
    step("t3_play", 0, 0, 3, 0);
    step("t3_loss_and_done", 0, 0, 0, 1);
    repeat (6) step("t3_over_screen", 0, 0, 3, 0);
    step("t3_restart", 1, 0, 3, 0);

    // Pause toggling and frozen loss detection while paused
    step("t4_play", 0, 0, 3, 0);
    step("t4_pause_rise", 0, 1, 3, 0);
    step("t4_life0_paused", 0, 1, 0, 0);
    step("t4_pause_release", 0, 0, 0, 0);
    step("t4_unpause", 0, 1, 0, 0);
    step("t4_loss_after", 0, 0, 0, 0);
    repeat (8) step("t4_drain", 0, 0, 3, 0);

    // Async reset in the middle of CLEAR
    step("t5_start", 1, 0, 3, 0);
    step("t5_play", 0, 0, 3, 0);
    step("t5_done", 0, 0, 3, 1);
    repeat (2) step("t5_clear", 0, 0, 3, 0);
    resetN = 1'b0;
    #1;
    model_reset();
    check("t5_async_reset");
    repeat (2) @(posedge clk);
    #1;
    check("t5_in_reset");
    resetN = 1'b1;
    repeat (3) step("t5_idle_wait", 0, 0, 3, 0);
    step("t5_restart", 1, 0, 3, 0);

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] lf;
      lf = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, lf, $urandom_range(0, 7) == 0);
    end

    // OVER_CYCLES=0 instance holds game over until reset
    check_hold("hold_idle", 9'b0);
    b_start_key = 1'b1;
    step("hold_drive", 0, 0, 3, 0);
    check_hold("hold_load", 9'b1_0_0_0_1_0000);
    b_start_key = 1'b0;
    step("hold_drive", 0, 0, 3, 0);
    check_hold("hold_play", 9'b1_0_0_0_0_0000);
    b_life = 4'd0;
    step("hold_drive", 0, 0, 3, 0);
    check_hold("hold_over", 9'b1_1_0_0_0_0000);
    for (int i = 0; i < 1000; i++) begin
      b_start_key = 1'($urandom_range(0, 1));
      b_level_done = 1'($urandom_range(0, 1));
      b_life = 4'($urandom_range(0, 15));
      step("hold_drive", 0, 0, 3, 0);
      check_hold("hold_over_forever", 9'b1_1_0_0_0_0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
